// File: rtl/full_adder_unit_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_unit_pkg
//   Shared constants and helpers for the registered full adder.
//   - RST_BIT / reset value for every output register
//   - MIN_WIDTH: smallest legal operand width
//   - fa_sum / fa_carry: single-bit full-adder equations, used by fa_cell so
//     the per-bit function lives in exactly one place
// -----------------------------------------------------------------------------
package full_adder_unit_pkg;

  localparam int unsigned MIN_WIDTH = 1;
  localparam logic        RST_BIT   = 1'b0;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/full_adder_unit_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Purely combinational 1-bit full adder; one ripple stage of full_adder_unit.
//   Ports:
//     a, b  : operand bits
//     cin   : carry into this bit
//     s     : sum bit
//     cout  : carry out of this bit
// -----------------------------------------------------------------------------
module fa_cell
  import full_adder_unit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder_unit.sv
// -----------------------------------------------------------------------------
// full_adder_unit
//   Registered ripple-carry adder: {cout, s} = a + b + cin (unsigned).
//   Result is captured on the clock edge where in_valid is high and shows up
//   one cycle later with out_valid asserted for that cycle. Between results
//   s/cout hold their last value.
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     in_valid   : a/b/cin valid this cycle
//     a, b       : WIDTH-bit operands
//     cin        : carry into bit 0
//     out_valid  : s/cout carry a fresh result this cycle
//     s          : registered WIDTH-bit sum
//     cout       : registered carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  if (WIDTH < int'(MIN_WIDTH)) begin : g_width_check
    $error("full_adder_unit: WIDTH must be at least 1");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // The data registers only load on in_valid, so X on idle operands never
  // reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= {WIDTH{RST_BIT}};
      cout      <= RST_BIT;
      out_valid <= RST_BIT;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_comb;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
module tb_full_adder_unit;

  logic       clk;
  logic       rst_n;

  logic       v1, a1, b1, c1;
  logic       ov1, s1, co1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       ov8, co8;
  logic [7:0] s8;

  int n_checks;
  int n_pass;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .s(s1), .cout(co1)
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .s(s8), .cout(co8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic at WIDTH+1 bits.
  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[8:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    #1;
    n_checks++;
    if ({ov1, s1, co1} !== 3'b000) $display("FAIL reset_w1: got %b expected 000", {ov1, s1, co1});
    else n_pass++;
    n_checks++;
    if ({ov8, s8, co8} !== 10'h0) $display("FAIL reset_w8: got %h expected 000", {ov8, s8, co8});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_sc [8];
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1;
      {c1, b1, a1} = 3'(i);
      @(posedge clk); #1;
      n_checks++;
      if ({ov1, s1, co1} !== {1'b1, exp_sc[i]})
        $display("FAIL truth_table[%0d]: got v,s,cout=%b expected %b", i, {ov1, s1, co1}, {1'b1, exp_sc[i]});
      else n_pass++;
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_hold_valid();
    @(negedge clk);
    v1 = 1'b1; a1 = 1; b1 = 0; c1 = 0;
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({ov1, s1, co1} !== 3'b110) $display("FAIL hold_capture: got %b expected 110", {ov1, s1, co1});
    else n_pass++;
    @(negedge clk);
    v1 = 1'b0; a1 = 1; b1 = 1; c1 = 1;
    v8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ov1, s1, co1} !== 3'b010) $display("FAIL hold_w1[%0d]: got %b expected 010", k, {ov1, s1, co1});
      else n_pass++;
      n_checks++;
      if ({ov8, co8, s8} !== {1'b0, 1'b0, 8'h46}) $display("FAIL hold_x_w8[%0d]: got %h expected 046", k, {ov8, co8, s8});
      else n_pass++;
    end
  endtask

  task automatic test_multibit();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [8:0] exp_v;
    ta = '{8'hFF, 8'h7F, 8'h12};
    tb = '{8'h01, 8'h80, 8'h34};
    tc = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      exp_v = ref_add8(ta[i], tb[i], tc[i]);
      @(posedge clk); #1;
      n_checks++;
      if ({ov8, co8, s8} !== {1'b1, exp_v})
        $display("FAIL multibit[%0d]: got v,cout,s=%h expected %h", i, {ov8, co8, s8}, {1'b1, exp_v});
      else n_pass++;
    end
    // Directed spot values as a sanity check on the model itself.
    n_checks++;
    if (ref_add8(8'h12, 8'h34, 1'b0) !== 9'h046 || s8 !== 8'h46)
      $display("FAIL multibit_const: got s=%h expected 46", s8);
    else n_pass++;
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [8:0] e8;
    logic [1:0] e1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      exp_q.push_back(ref_add8(a8, b8, c8));
      exp1_q.push_back(2'(int'(a1) + int'(b1) + int'(c1)));
      @(posedge clk); #1;
      e8 = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      n_checks++;
      if ({ov8, co8, s8} !== {1'b1, e8})
        $display("FAIL b2b_w8[%0d]: got v,cout,s=%h expected %h", i, {ov8, co8, s8}, {1'b1, e8});
      else n_pass++;
      n_checks++;
      if ({ov1, co1, s1} !== {1'b1, e1})
        $display("FAIL b2b_w1[%0d]: got v,cout,s=%b expected %b", i, {ov1, co1, s1}, {1'b1, e1});
      else n_pass++;
    end
    @(negedge clk);
    v8 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ov8, ov1} !== 2'b00) $display("FAIL b2b_valid_drop: got %b expected 00", {ov8, ov1});
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    v1 = 1'b1; a1 = 1; b1 = 0; c1 = 0;
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; c8 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({ov1, s1} !== 2'b11) $display("FAIL rst_pre: got %b expected 11", {ov1, s1});
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov1, s1, co1} !== 3'b000) $display("FAIL rst_async_w1: got %b expected 000", {ov1, s1, co1});
    else n_pass++;
    n_checks++;
    if ({ov8, s8, co8} !== 10'h0) $display("FAIL rst_async_w8: got %h expected 000", {ov8, s8, co8});
    else n_pass++;
    // in_valid still high across an edge while in reset: reset wins.
    @(posedge clk); #1;
    n_checks++;
    if ({ov1, s1, co1, ov8, s8, co8} !== 13'h0) $display("FAIL rst_wins: got %h expected 0", {ov1, s1, co1, ov8, s8, co8});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0; v8 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ov1, ov8} !== 2'b00) $display("FAIL rst_no_stale: got %b expected 00", {ov1, ov8});
    else n_pass++;
    @(negedge clk);
    v1 = 1'b1; a1 = 1; b1 = 1; c1 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({ov1, s1, co1} !== 3'b111) $display("FAIL rst_first_capture: got %b expected 111", {ov1, s1, co1});
    else n_pass++;
    @(negedge clk);
    v1 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_truth_table();
    test_hold_valid();
    test_multibit();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
